// File: rtl/branch_ctrl_if.sv
// Decode-side request channel and fetch/commit-side response channel of branch_ctrl.
`ifndef CMP_OP_WIDTH
`define CMP_OP_WIDTH 3
`endif

interface branch_ctrl_if #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32
);
  logic                     i_req_valid;
  logic                     o_req_ready;
  logic [`CMP_OP_WIDTH-1:0] i_req_op;
  logic [WIDTH-1:0]         i_req_src1;
  logic [WIDTH-1:0]         i_req_src2;
  logic [PC_WIDTH-1:0]      i_req_pc;
  logic [PC_WIDTH-1:0]      i_req_imm;
  logic                     i_req_pred_taken;
  logic                     o_resp_valid;
  logic                     i_resp_ready;
  logic                     o_resp_taken;
  logic                     o_resp_mispredict;
  logic [PC_WIDTH-1:0]      o_resp_next_pc;

  modport master (
    output i_req_valid, i_req_op, i_req_src1, i_req_src2, i_req_pc, i_req_imm,
           i_req_pred_taken, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_taken, o_resp_mispredict, o_resp_next_pc
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_src1, i_req_src2, i_req_pc, i_req_imm,
           i_req_pred_taken, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_taken, o_resp_mispredict, o_resp_next_pc
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch sequencer around the external cmp comparator: IDLE -> EVAL -> RESP.
// Optional BRANCH_CTRL_STATS_EN adds saturating branch/mispredict counters.
`ifndef CMP_OP_WIDTH
`define CMP_OP_WIDTH 3
`endif

module branch_ctrl #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  branch_ctrl_if.slave             bus,
  output logic [`CMP_OP_WIDTH-1:0] o_cmp_op,
  output logic [WIDTH-1:0]         o_cmp_src1,
  output logic [WIDTH-1:0]         o_cmp_src2,
  input  logic                     i_cmp_taken,
  input  logic                     i_flush,
  output logic                     o_busy
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]              o_stat_branches,
  output logic [31:0]              o_stat_mispredicts
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  typedef struct packed {
    logic [`CMP_OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]         src1;
    logic [WIDTH-1:0]         src2;
    logic [PC_WIDTH-1:0]      pc;
    logic [PC_WIDTH-1:0]      imm;
    logic                     pred;
  } req_t;

  state_e              state_q;
  req_t                req_q, req_d;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                taken_q;
  logic                mispredict_q;
  logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;
  logic                busy_q;

  assign req_d = '{op:   bus.i_req_op,
                   src1: bus.i_req_src1,
                   src2: bus.i_req_src2,
                   pc:   bus.i_req_pc,
                   imm:  bus.i_req_imm,
                   pred: bus.i_req_pred_taken};

  // PC adds wrap silently at PC_WIDTH bits.
  assign next_pc_d = i_cmp_taken ? (req_q.pc + req_q.imm) : (req_q.pc + PC_WIDTH'(4));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      next_pc_q    <= '0;
      busy_q       <= 1'b0;
    end else if (i_flush) begin
      // Kills whatever is in flight; an incoming request this cycle is dropped.
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_req_valid) begin
            req_q       <= req_d;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= EVAL;
          end
        end
        EVAL: begin
          taken_q      <= i_cmp_taken;
          mispredict_q <= i_cmp_taken ^ req_q.pred;
          next_pc_q    <= next_pc_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Comparator operands come straight from the latched request and hold outside EVAL.
  assign o_cmp_op   = req_q.op;
  assign o_cmp_src1 = req_q.src1;
  assign o_cmp_src2 = req_q.src2;

  assign bus.o_req_ready       = req_ready_q;
  assign bus.o_resp_valid      = resp_valid_q;
  assign bus.o_resp_taken      = taken_q;
  assign bus.o_resp_mispredict = mispredict_q;
  assign bus.o_resp_next_pc    = next_pc_q;
  assign o_busy                = busy_q;

`ifdef BRANCH_CTRL_STATS_EN
  logic        resp_hs;
  logic [31:0] stat_br_q, stat_mis_q;

  // A response taken in the same cycle as a flush still counts as delivered.
  assign resp_hs = resp_valid_q & bus.i_resp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (resp_hs) begin
      if (stat_br_q != '1)                  stat_br_q  <= stat_br_q + 32'd1;
      if (mispredict_q && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign o_stat_branches    = stat_br_q;
  assign o_stat_mispredicts = stat_mis_q;
`endif

`ifndef SYNTHESIS
  a_cmp_known: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == EVAL) |-> !$isunknown(i_cmp_taken));
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl; the bench also plays the external cmp comparator.
`ifndef CMP_OP_WIDTH
`define CMP_OP_WIDTH 3
`endif

module tb_branch_ctrl;
  localparam int W   = 32;
  localparam int PW  = 32;
  localparam int OPW = `CMP_OP_WIDTH;
  localparam logic [OPW-1:0] BEQ = 0, BNE = 1, BLT = 4, BGE = 5, BLTU = 6, BGEU = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_ctrl_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

  logic [OPW-1:0] cmp_op;
  logic [W-1:0]   cmp_s1, cmp_s2;
  logic           cmp_taken;
  logic           busy;
  logic           flush_w;
  logic           rand_en = 1'b0;
  logic           rnd_ready, rnd_flush;
  logic           dir_ready = 1'b1, dir_flush = 1'b0;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0]    stat_br, stat_mis;
`endif

  assign bus.i_resp_ready = rand_en ? rnd_ready : dir_ready;
  assign flush_w          = rand_en ? rnd_flush : dir_flush;

  branch_ctrl #(.WIDTH(W), .PC_WIDTH(PW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_cmp_op    (cmp_op),
    .o_cmp_src1  (cmp_s1),
    .o_cmp_src2  (cmp_s2),
    .i_cmp_taken (cmp_taken),
    .i_flush     (flush_w),
    .o_busy      (busy)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .o_stat_branches    (stat_br),
    .o_stat_mispredicts (stat_mis)
`endif
  );

  function automatic logic ref_taken(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      BEQ:     return a == b;
      BNE:     return a != b;
      BLT:     return $signed(a) <  $signed(b);
      BGE:     return $signed(a) >= $signed(b);
      BLTU:    return a <  b;
      BGEU:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign cmp_taken = ref_taken(cmp_op, cmp_s1, cmp_s2);

  typedef struct {
    logic          taken;
    logic          mis;
    logic [PW-1:0] npc;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   exp_br = 0, exp_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops on a response handshake.
  initial begin
    logic          prev_valid = 0, prev_hs = 0, prev_flush = 0, hold = 0;
    logic          h_taken = 0, h_mis = 0;
    logic [PW-1:0] h_npc = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev_valid = 0; prev_hs = 0; prev_flush = 0; hold = 0;
        exp_br = 0; exp_mis = 0;
      end else begin
        if (prev_flush || prev_hs) begin
          chk("idle_after_end.valid", bus.o_resp_valid, 0);
          chk("idle_after_end.ready", bus.o_req_ready, 1);
          chk("idle_after_end.busy",  busy, 0);
        end
        if (hold) begin
          chk("stall.valid",   bus.o_resp_valid, 1);
          chk("stall.req_rdy", bus.o_req_ready, 0);
          chk("stall.taken",   bus.o_resp_taken, h_taken);
          chk("stall.mis",     bus.o_resp_mispredict, h_mis);
          chk("stall.npc",     bus.o_resp_next_pc, h_npc);
        end
        if (bus.o_resp_valid) begin
          chk("resp_expected", q.size() > 0, 1);
          if (q.size() > 0 && !prev_valid) chk("latency", cyc - q[0].acc, 2);
          if (bus.i_resp_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("resp.taken", bus.o_resp_taken, e.taken);
            chk("resp.mis",   bus.o_resp_mispredict, e.mis);
            chk("resp.npc",   bus.o_resp_next_pc, e.npc);
            exp_br++;
            if (e.mis) exp_mis++;
          end
        end
        hold    = bus.o_resp_valid && !bus.i_resp_ready && !flush_w;
        h_taken = bus.o_resp_taken;
        h_mis   = bus.o_resp_mispredict;
        h_npc   = bus.o_resp_next_pc;
        prev_hs    = bus.o_resp_valid && bus.i_resp_ready;
        prev_flush = flush_w;
        prev_valid = bus.o_resp_valid;
        if (flush_w) q.delete();
      end
    end
  end

  initial begin
    rnd_ready = 1'b0;
    rnd_flush = 1'b0;
    forever begin
      @(posedge clk); #1;
      rnd_ready = ($urandom_range(0, 9) < 6);
      rnd_flush = ($urandom_range(0, 99) < 4);
    end
  end

  task automatic send(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [PW-1:0] pc, input logic [PW-1:0] imm, input logic pred);
    exp_t e;
    bit   done = 0;
    @(posedge clk); #1;
    bus.i_req_valid      = 1'b1;
    bus.i_req_op         = op;
    bus.i_req_src1       = a;
    bus.i_req_src2       = b;
    bus.i_req_pc         = pc;
    bus.i_req_imm        = imm;
    bus.i_req_pred_taken = pred;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.o_req_ready) begin
        done = 1;
        if (!flush_w) begin
          e.taken = ref_taken(op, a, b);
          e.npc   = e.taken ? pc + imm : pc + 32'd4;
          e.mis   = e.taken ^ pred;
          e.acc   = cyc;
          q.push_back(e);
        end
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: ready never seen, required 1");
    end
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OPW-1:0] ops [6];
    logic [W-1:0]   a, b;
    ops[0] = BEQ; ops[1] = BNE; ops[2] = BLT; ops[3] = BGE; ops[4] = BLTU; ops[5] = BGEU;
    bus.i_req_valid = 0; bus.i_req_op = '0; bus.i_req_src1 = '0; bus.i_req_src2 = '0;
    bus.i_req_pc = '0; bus.i_req_imm = '0; bus.i_req_pred_taken = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst.req_ready", bus.o_req_ready, 1);
    chk("rst.valid",     bus.o_resp_valid, 0);
    chk("rst.taken",     bus.o_resp_taken, 0);
    chk("rst.mis",       bus.o_resp_mispredict, 0);
    chk("rst.npc",       bus.o_resp_next_pc, 0);
    chk("rst.busy",      busy, 0);
    chk("rst.cmp_op",    cmp_op, 0);
    chk("rst.cmp_s1",    cmp_s1, 0);
    chk("rst.cmp_s2",    cmp_s2, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Directed: taken/predicted, not-taken/mispredicted, wrap-around
    send(BEQ, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1);            idle(3);
    send(BLT, 32'h1, 32'hFFFF_FFFF, 32'h200, 32'h40, 1'b1);    idle(3);
    send(BNE, 32'h3, 32'h4, 32'hFFFF_FFF0, 32'h20, 1'b1);      idle(3);

    // Flush while evaluating
    send(BEQ, 32'h7, 32'h7, 32'h300, 32'h8, 1'b0);
    dir_flush = 1'b1; idle(1); dir_flush = 1'b0; idle(3);
`ifdef BRANCH_CTRL_STATS_EN
    chk("stat.branches",    stat_br, 3);
    chk("stat.mispredicts", stat_mis, 1);
`endif

    // Backpressure for several cycles
    dir_ready = 1'b0;
    send(BGEU, 32'hFFFF_FFFF, 32'h1, 32'h400, 32'h100, 1'b0);
    idle(6);
    dir_ready = 1'b1; idle(3);

    // Flush while holding a response
    dir_ready = 1'b0;
    send(BLTU, 32'h1, 32'h2, 32'h500, 32'h10, 1'b1);
    idle(1);
    dir_flush = 1'b1; idle(1); dir_flush = 1'b0; dir_ready = 1'b1; idle(3);

    // Flush coincident with the response handshake: delivered
    send(BGE, 32'h8000_0000, 32'h1, 32'h600, 32'hFFFF_FFF0, 1'b1);
    idle(1);
    dir_flush = 1'b1; idle(1); dir_flush = 1'b0; idle(3);

    // Flush coincident with the request handshake: dropped
    dir_flush = 1'b1;
    send(BEQ, 32'h0, 32'h0, 32'h700, 32'h4, 1'b0);
    dir_flush = 1'b0; idle(4);

    // Asynchronous reset with a response pending
    dir_ready = 1'b0;
    send(BNE, 32'h1, 32'h2, 32'h800, 32'h40, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid",     bus.o_resp_valid, 0);
    chk("midrst.req_ready", bus.o_req_ready, 1);
    chk("midrst.busy",      busy, 0);
    chk("midrst.npc",       bus.o_resp_next_pc, 0);
    chk("midrst.cmp_s1",    cmp_s1, 0);
    idle(1);
    rst_n = 1'b1;
    dir_ready = 1'b1;
    idle(4);

    // Randomized traffic with random backpressure and flushes
    rand_en = 1'b1;
    repeat (150) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom();
      endcase
      send(ops[$urandom_range(0, 5)], a, b, $urandom() & ~32'h3,
           ($urandom_range(0, 1) != 0) ? $urandom() : {{20{1'b1}}, 12'($urandom())},
           1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end
    rand_en   = 1'b0;
    dir_ready = 1'b1;
    dir_flush = 1'b0;
    for (int i = 0; i < 50 && (q.size() != 0 || busy); i++) idle(1);
    idle(2);
    chk("drain.queue_empty", q.size(), 0);
    chk("drain.busy", busy, 0);
`ifdef BRANCH_CTRL_STATS_EN
    chk("stat.final_branches",    stat_br, exp_br);
    chk("stat.final_mispredicts", stat_mis, exp_mis);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
